uart_tx_ser: RTL and testbench

Byte-serial UART transmitter that sits directly downstream of the load/store unit's transmit handshake. It accepts a byte when the active-low start request is sampled low, shifts it out on the serial line as a standard 8N1 frame (optionally 8E1), and returns a single-cycle completion pulse. The load/store unit uses this pulse to step its flag/address/data sequence. The block latches each byte exactly once, even though the request stays held low across consecutive bytes.

---
 rtl/uart_tx_ser.sv | 149 ++++++++++++++
 tb/tb_uart_tx_ser.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_ser.sv
// Byte-serial UART transmitter: 8N1 frames, or 8E1 when UART_PARITY_EN is defined.
// Latency: line falls on the acceptance edge; tx_done pulses one cycle after the stop bit.
// Backpressure: tx_start is ignored while busy and during the DONE cycle.
module uart_tx_ser #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       tx_done,
  output logic       tx_busy,
  output logic       tx
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_PARITY_EN
    S_PARITY,
`endif
    S_STOP,
    S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;
  logic          tx_done_q, tx_done_d;
  logic          bit_end;
`ifdef UART_PARITY_EN
  logic          par_q, par_d;
`endif

  assign bit_end = (cnt_q == CNT_MAX);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
`ifdef UART_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (!tx_start) begin
          shift_d = tx_data;
`ifdef UART_PARITY_EN
          par_d   = ^tx_data;
`endif
          cnt_d   = '0;
          bit_d   = '0;
          state_d = S_START;
        end
      end
      S_START: begin
        if (bit_end) begin
          cnt_d   = '0;
          state_d = S_DATA;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DATA: begin
        if (bit_end) begin
          cnt_d   = '0;
          shift_d = {1'b0, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
`ifdef UART_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
`ifdef UART_PARITY_EN
      S_PARITY: begin
        if (bit_end) begin
          cnt_d   = '0;
          state_d = S_STOP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
`endif
      S_STOP: begin
        if (bit_end) begin
          cnt_d   = '0;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Line and done are registered from the next state so they change on the same edge as it.
    case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shift_d[0];
`ifdef UART_PARITY_EN
      S_PARITY: tx_d = par_d;
`endif
      default:  tx_d = 1'b1;
    endcase
    tx_done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      tx_q      <= 1'b1;
      tx_done_q <= 1'b0;
`ifdef UART_PARITY_EN
      par_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
      tx_done_q <= tx_done_d;
`ifdef UART_PARITY_EN
      par_q     <= par_d;
`endif
    end
  end

  assign tx      = tx_q;
  assign tx_done = tx_done_q;
  assign tx_busy = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_tx_ser.sv
// Directed bench for uart_tx_ser at CLKS_PER_BIT=4; honours UART_PARITY_EN like the design.
module tb_uart_tx_ser;

  localparam int C = 4;
`ifdef UART_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       tx_start = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_done, tx_busy, tx;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  uart_tx_ser #(.CLKS_PER_BIT(C)) dut (
    .clk(clk), .reset(reset), .tx_start(tx_start), .tx_data(tx_data),
    .tx_done(tx_done), .tx_busy(tx_busy), .tx(tx)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected line value in cycle E+n of a frame carrying b.
  function automatic logic exp_line(input logic [7:0] b, input int n);
    int idx;
    idx = (n - 1) / C;
    if (idx == 0) return 1'b0;
    if (idx <= 8) return b[idx-1];
`ifdef UART_PARITY_EN
    if (idx == 9) return ^b;
`endif
    return 1'b1;
  endfunction

  // Called at the negedge of cycle E+1; checks every cycle of the frame and a few after.
  task automatic check_frame(input logic [7:0] b, input string tag);
    for (int n = 1; n <= NB * C + 3; n++) begin
      chk({tag, "_tx"}, tx, exp_line(b, n));
      chk({tag, "_done"}, tx_done, (n == NB * C + 1));
      chk({tag, "_busy"}, tx_busy, (n <= NB * C + 1));
      @(negedge clk);
    end
  endtask

  // Receiver model: find the start bit, then sample every bit at its middle.
  task automatic decode(output logic [7:0] b, output logic par, output logic ok,
                        output int start_cyc);
    int w;
    b = 8'h00; par = 1'b0; ok = 1'b0; start_cyc = -1;
    w = 0;
    while (tx !== 1'b0 && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (tx !== 1'b0) begin
      chk("start_timeout", 1, 0);
      return;
    end
    start_cyc = cyc;
    repeat (C / 2) @(negedge clk);
    if (tx !== 1'b0) return;
    for (int k = 0; k < 8; k++) begin
      repeat (C) @(negedge clk);
      b[k] = tx;
    end
`ifdef UART_PARITY_EN
    repeat (C) @(negedge clk);
    par = tx;
`endif
    repeat (C) @(negedge clk);
    ok = (tx === 1'b1);
  endtask

  task automatic wait_done(output int dcyc);
    int w;
    w = 0;
    dcyc = -1;
    while (tx_done !== 1'b1 && w < 3 * C) begin
      @(negedge clk);
      w++;
    end
    chk("done_seen", tx_done, 1'b1);
    dcyc = cyc;
  endtask

  task automatic accept_one(input logic [7:0] b);
    @(negedge clk);
    tx_data  = b;
    tx_start = 1'b0;
    @(negedge clk);
    tx_start = 1'b1;
  endtask

  logic [7:0] rb;
  logic       rp, rok;
  int         s1, s2, d1, d2;

  initial begin
    // Reset state and idle observation
    repeat (3) @(negedge clk);
    chk("rst_tx", tx, 1'b1);
    chk("rst_done", tx_done, 1'b0);
    chk("rst_busy", tx_busy, 1'b0);
    reset = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      chk("idle_line", {tx, tx_done, tx_busy}, 3'b100);
    end

    // Single byte 0x01, exact cycle-by-cycle line
    accept_one(8'h01);
    check_frame(8'h01, "b01");

    // Back-to-back with tx_start held low
    @(negedge clk);
    tx_data  = 8'h02;
    tx_start = 1'b0;
    decode(rb, rp, rok, s1);
    chk("b2b_first", rb, 8'h02);
    chk("b2b_first_stop", rok, 1'b1);
    wait_done(d1);
    @(posedge clk);
    #1 tx_data = 8'hA5;
    decode(rb, rp, rok, s2);
    chk("b2b_second", rb, 8'hA5);
    chk("b2b_second_stop", rok, 1'b1);
    chk("b2b_gap", s2 - d1, 2);
    wait_done(d2);
    chk("b2b_period", d2 - d1, NB * C + 2);
    tx_start = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      chk("b2b_no_dup", {tx, tx_busy}, 2'b10);
    end

    // tx_data scrambled during a frame of 0x3C
    accept_one(8'h3C);
    fork
      decode(rb, rp, rok, s1);
      for (int i = 0; i < NB * C; i++) begin
        tx_data = 8'($urandom);
        @(negedge clk);
      end
    join
    chk("scramble_byte", rb, 8'h3C);
    chk("scramble_stop", rok, 1'b1);
    repeat (2 * C) @(negedge clk);

    // Reset during data bit 3 of 0x00
    accept_one(8'h00);
    repeat (17) @(negedge clk);
    chk("mid_tx_bit3", tx, 1'b0);
    chk("mid_busy", tx_busy, 1'b1);
    reset = 1'b0;
    @(negedge clk);
    chk("mid_rst_tx", tx, 1'b1);
    chk("mid_rst_busy", tx_busy, 1'b0);
    chk("mid_rst_done", tx_done, 1'b0);
    reset = 1'b1;
    for (int i = 0; i < NB * C; i++) begin
      @(negedge clk);
      chk("mid_no_done", {tx, tx_done, tx_busy}, 3'b100);
    end
    accept_one(8'h55);
    check_frame(8'h55, "b55");

`ifdef UART_PARITY_EN
    // Even parity: 0x07 has three ones, 0x03 has two
    accept_one(8'h07);
    check_frame(8'h07, "p07");
    accept_one(8'h07);
    decode(rb, rp, rok, s1);
    chk("p07_byte", rb, 8'h07);
    chk("p07_par", rp, 1'b1);
    chk("p07_stop", rok, 1'b1);
    repeat (2 * C) @(negedge clk);
    accept_one(8'h03);
    decode(rb, rp, rok, s1);
    chk("p03_byte", rb, 8'h03);
    chk("p03_par", rp, 1'b0);
    chk("p03_stop", rok, 1'b1);
    repeat (2 * C) @(negedge clk);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
